// File: rtl/i2s_audio_tx.sv
// I2S transmitter: double-buffered 16-bit stereo pairs serialized onto bclk/lrclk/sdata.
// The frame boundary doubles as the upstream sample-rate strobe (frame_tick).
module i2s_audio_tx #(
   parameter int BCLK_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] left_in,
   input  logic [15:0] right_in,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        bclk,
   output logic        lrclk,
   output logic        sdata,
   output logic        frame_tick,
   output logic        underrun
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [4:0]       slot;
   logic [4:0]       slot_next;
   logic [31:0]      shift_reg;
   logic [15:0]      hold_l;
   logic [15:0]      hold_r;
   logic             hold_full;
   logic             div_tc;
   logic             fall_evt;
   logic             boundary;
   logic             accept;

   assign div_tc       = (div_cnt == DIV_LAST);
   assign fall_evt     = div_tc & bclk;
   assign slot_next    = slot + 5'd1;
   assign boundary     = fall_evt & (slot_next == 5'd0);
   assign accept       = sample_valid & ~hold_full;
   assign sample_ready = ~hold_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt    <= '0;
         bclk       <= 1'b0;
         slot       <= 5'd31;
         lrclk      <= 1'b0;
         sdata      <= 1'b0;
         shift_reg  <= '0;
         hold_l     <= '0;
         hold_r     <= '0;
         hold_full  <= 1'b0;
         frame_tick <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         frame_tick <= boundary;
         underrun   <= boundary & ~hold_full;
         div_cnt    <= div_tc ? '0 : div_cnt + DIV_W'(1);
         if (div_tc) begin
            bclk <= ~bclk;
         end
         // sdata takes the shifter MSB one slot late; at the boundary that is
         // the previous frame's R[0], giving the one-BCLK I2S delay.
         if (fall_evt) begin
            slot  <= slot_next;
            lrclk <= slot_next[4];
            sdata <= shift_reg[31];
            if (boundary) begin
               shift_reg <= hold_full ? {hold_l, hold_r} : 32'h0;
            end else begin
               shift_reg <= {shift_reg[30:0], 1'b0};
            end
         end
         // Accept and transfer are exclusive: accept needs hold empty, transfer clears a full hold.
         if (accept) begin
            hold_l    <= left_in;
            hold_r    <= right_in;
            hold_full <= 1'b1;
         end else if (boundary) begin
            hold_full <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: two instances (BCLK_DIV=4 and 1) share stimulus and are
// checked every cycle against a cycle-arithmetic model of the frame/slot timing.
module tb_i2s_audio_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] left_in;
   logic [15:0] right_in;
   logic        sample_valid;
   logic [1:0]  rdy;
   logic [1:0]  bclk_w;
   logic [1:0]  lr_w;
   logic [1:0]  sd_w;
   logic [1:0]  tick_w;
   logic [1:0]  und_w;

   always #5 clk = ~clk;

   i2s_audio_tx #(.BCLK_DIV(4)) dut_div4 (
      .clk          (clk),
      .reset        (reset),
      .left_in      (left_in),
      .right_in     (right_in),
      .sample_valid (sample_valid),
      .sample_ready (rdy[0]),
      .bclk         (bclk_w[0]),
      .lrclk        (lr_w[0]),
      .sdata        (sd_w[0]),
      .frame_tick   (tick_w[0]),
      .underrun     (und_w[0])
   );

   i2s_audio_tx #(.BCLK_DIV(1)) dut_div1 (
      .clk          (clk),
      .reset        (reset),
      .left_in      (left_in),
      .right_in     (right_in),
      .sample_valid (sample_valid),
      .sample_ready (rdy[1]),
      .bclk         (bclk_w[1]),
      .lrclk        (lr_w[1]),
      .sdata        (sd_w[1]),
      .frame_tick   (tick_w[1]),
      .underrun     (und_w[1])
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int div_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic bit is_bnd(input int d, input int k);
      return (k >= 2 * d) && (((k - 2 * d) % (64 * d)) == 0);
   endfunction

   // Reference model: cyc = rising edges since reset release; frame f loads at edge 2d+64d*f.
   int          cyc = 0;
   bit          armed = 1'b0;
   bit          m_full [2];
   bit          m_under [2];
   logic [15:0] m_l [2];
   logic [15:0] m_r [2];
   logic [31:0] words [2][256];

   always @(posedge clk) begin
      armed <= 1'b1;
      if (reset) begin
         cyc <= 0;
         for (int i = 0; i < 2; i++) begin
            m_full[i]  <= 1'b0;
            m_under[i] <= 1'b0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int i = 0; i < 2; i++) begin
            if (is_bnd(div_of(i), cyc + 1)) begin
               words[i][(cyc + 1 - 2 * div_of(i)) / (64 * div_of(i))] <=
                  m_full[i] ? {m_l[i], m_r[i]} : 32'h0;
            end
            m_under[i] <= is_bnd(div_of(i), cyc + 1) && !m_full[i];
            if (sample_valid && !m_full[i]) begin
               m_full[i] <= 1'b1;
               m_l[i]    <= left_in;
               m_r[i]    <= right_in;
            end else if (is_bnd(div_of(i), cyc + 1)) begin
               m_full[i] <= 1'b0;
            end
         end
      end
   end

   int   mon_d, mon_j, mon_s, mon_f;
   logic mon_sd, mon_lr;

   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < 2; i++) begin
            mon_d  = div_of(i);
            mon_sd = 1'b0;
            mon_lr = 1'b0;
            if (cyc >= 2 * mon_d) begin
               mon_j  = cyc / (2 * mon_d) - 1;
               mon_s  = mon_j % 32;
               mon_f  = mon_j / 32;
               mon_lr = (mon_s >= 16);
               if (mon_s != 0) mon_sd = words[i][mon_f][32 - mon_s];
               else if (mon_f != 0) mon_sd = words[i][mon_f - 1][0];
            end
            check($sformatf("bclk[div%0d]", mon_d), 32'(bclk_w[i]), 32'((cyc / mon_d) % 2));
            check($sformatf("lrclk[div%0d]", mon_d), 32'(lr_w[i]), 32'(mon_lr));
            check($sformatf("sdata[div%0d]", mon_d), 32'(sd_w[i]), 32'(mon_sd));
            check($sformatf("frame_tick[div%0d]", mon_d), 32'(tick_w[i]),
                  32'(is_bnd(mon_d, cyc)));
            check($sformatf("underrun[div%0d]", mon_d), 32'(und_w[i]), 32'(m_under[i]));
            check($sformatf("ready[div%0d]", mon_d), 32'(rdy[i]), 32'(!m_full[i]));
         end
      end
   end

   task automatic do_reset(input int n);
      reset        = 1'b1;
      sample_valid = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   bit acc_now;
   int acc_cnt, tick_cnt, und_cnt;

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      left_in      = 16'h0;
      right_in     = 16'h0;
      @(negedge clk);

      // Idle after reset: silence with underrun every frame.
      do_reset(3);
      idle(3 * 256 + 20);

      // Single pair accepted at edge 1, transferred at edge 8.
      do_reset(2);
      left_in      = 16'hA5C3;
      right_in     = 16'h0F01;
      sample_valid = 1'b1;
      @(negedge clk);
      check("s2_ready_low", 32'(rdy[0]), 32'd0);
      sample_valid = 1'b0;
      idle(7);
      check("s2_tick", 32'(tick_w[0]), 32'd1);
      check("s2_no_underrun", 32'(und_w[0]), 32'd0);
      check("s2_ready_back", 32'(rdy[0]), 32'd1);
      idle(2 * 256 + 20);

      // Continuous stream, pair increments on each accept by the div4 instance.
      do_reset(2);
      left_in      = 16'h1000;
      right_in     = 16'h8F00;
      sample_valid = 1'b1;
      acc_cnt  = 0;
      tick_cnt = 0;
      und_cnt  = 0;
      for (int n = 0; n < 2560; n++) begin
         acc_now = rdy[0];
         @(negedge clk);
         if (acc_now) begin
            acc_cnt++;
            left_in  = left_in + 16'd1;
            right_in = right_in + 16'd3;
         end
         if (tick_w[0]) tick_cnt++;
         if (und_w[0]) und_cnt++;
      end
      sample_valid = 1'b0;
      check("s3_ticks", 32'(tick_cnt), 32'd10);
      check("s3_accepts", 32'(acc_cnt), 32'(tick_cnt + 1));
      check("s3_underruns", 32'(und_cnt), 32'd0);
      idle(300);

      // Valid rises on the boundary edge with hold empty.
      do_reset(2);
      idle(7);
      left_in      = 16'($urandom);
      right_in     = 16'($urandom);
      sample_valid = 1'b1;
      @(negedge clk);
      check("s4_underrun", 32'(und_w[0]), 32'd1);
      check("s4_tick", 32'(tick_w[0]), 32'd1);
      check("s4_ready_low", 32'(rdy[0]), 32'd0);
      sample_valid = 1'b0;
      idle(2 * 256 + 20);

      // Reset for one cycle in slot 20 with hold full.
      do_reset(2);
      left_in      = 16'($urandom);
      right_in     = 16'($urandom);
      sample_valid = 1'b1;
      idle(170);
      check("s5_hold_full", 32'(rdy[0]), 32'd0);
      reset        = 1'b1;
      sample_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("s5_ready", 32'(rdy[0]), 32'd1);
      check("s5_bclk", 32'(bclk_w[0]), 32'd0);
      check("s5_lrclk", 32'(lr_w[0]), 32'd0);
      check("s5_sdata", 32'(sd_w[0]), 32'd0);
      check("s5_tick_clear", 32'(tick_w[0]), 32'd0);
      idle(8);
      check("s5_first_tick", 32'(tick_w[0]), 32'd1);
      check("s5_underrun", 32'(und_w[0]), 32'd1);
      idle(300);

      // Random valid and data.
      do_reset(2);
      for (int n = 0; n < 1600; n++) begin
         sample_valid = ($urandom_range(0, 3) == 0);
         left_in      = 16'($urandom);
         right_in     = 16'($urandom);
         @(negedge clk);
      end
      sample_valid = 1'b0;
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
